// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl
// Staged reset release for the bus fabric, I/O peripherals and CPU.
// Waits for a synchronized clock-lock indication, holds every domain in reset,
// and then releases bus, io and cpu one after another. Lock loss, a watchdog
// expiry or a software request puts the domains back into reset, and the
// cause of the last re-entry is recorded.

module reset_seq_ctrl #(
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_CYC = 4,
    parameter int WDT_CYC   = 65536,
    parameter int CNT_W     = 8,
    parameter int WDT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       sw_reset_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       bus_reset,
    output logic       io_reset,
    output logic       cpu_reset,
    output logic       seq_busy,
    output logic [1:0] reset_cause
);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        REL_BUS,
        REL_IO,
        RUN
    } state_t;

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
    localparam logic [1:0] CAUSE_LOCK = 2'b11;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
    localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WDT_W-1:0] wdt_cnt, wdt_cnt_nx;
    logic [1:0]       cause_nx;
    logic             locked_m, locked_s;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (reset) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    // Next-state, counter and cause decode; re-entry events by priority.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nx   = state;
        cnt_nx     = cnt;
        wdt_cnt_nx = '0;
        cause_nx   = reset_cause;

        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cause_nx = CAUSE_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = REL_BUS;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            REL_BUS, REL_IO: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cause_nx = CAUSE_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STAGE_LAST) begin
                    state_nx = (state == REL_BUS) ? REL_IO : RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cause_nx = CAUSE_LOCK;
                end else if (wdt_en && !wdt_kick && wdt_cnt == WDT_LAST) begin
                    state_nx = HOLD;
                    cause_nx = CAUSE_WDT;
                end else if (sw_reset_req) begin
                    state_nx = HOLD;
                    cause_nx = CAUSE_SW;
                end else if (wdt_en && !wdt_kick) begin
                    wdt_cnt_nx = wdt_cnt + WDT_W'(1);
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            wdt_cnt     <= '0;
            bus_reset   <= 1'b1;
            io_reset    <= 1'b1;
            cpu_reset   <= 1'b1;
            seq_busy    <= 1'b1;
            reset_cause <= CAUSE_EXT;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            wdt_cnt     <= wdt_cnt_nx;
            bus_reset   <= (state_nx == WAIT_LOCK) || (state_nx == HOLD);
            io_reset    <= (state_nx != REL_IO) && (state_nx != RUN);
            cpu_reset   <= (state_nx != RUN);
            seq_busy    <= (state_nx != RUN);
            reset_cause <= cause_nx;
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb_reset_seq_ctrl
// Directed timing checks plus randomized stimulus compared every cycle with
// a reference model that tracks "cycles since the hold phase began" and
// derives each domain reset from that age.

module tb_reset_seq_ctrl;

    localparam int H = 4;
    localparam int S = 2;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset, locked, sw_reset_req, wdt_en, wdt_kick;
    logic       bus_reset, io_reset, cpu_reset, seq_busy;
    logic [1:0] reset_cause;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    bit         m_wait;
    int         m_age;
    int         m_wdt;
    logic [1:0] m_cause;
    logic       m_s1, m_s2;

    reset_seq_ctrl #(
        .HOLD_CYC (H),
        .STAGE_CYC(S),
        .WDT_CYC  (W),
        .CNT_W    (8),
        .WDT_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .locked      (locked),
        .sw_reset_req(sw_reset_req),
        .wdt_en      (wdt_en),
        .wdt_kick    (wdt_kick),
        .bus_reset   (bus_reset),
        .io_reset    (io_reset),
        .cpu_reset   (cpu_reset),
        .seq_busy    (seq_busy),
        .reset_cause (reset_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [5:0] model_outs();
        if (m_wait)
            return {4'b1111, m_cause};
        return {m_age < H, m_age < H + S, m_age < H + 2 * S, m_age < H + 2 * S, m_cause};
    endfunction

    // Advance the model by one clock edge using the pre-edge inputs.
    task automatic model_edge();
        bit ls, running, expire;
        if (reset) begin
            m_wait  = 1'b1;
            m_age   = 0;
            m_wdt   = 0;
            m_cause = 2'b00;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            ls      = m_s2;
            running = !m_wait && (m_age >= H + 2 * S);
            expire  = wdt_en && !wdt_kick && (m_wdt == W - 1);
            if (m_wait) begin
                if (ls) begin
                    m_wait = 1'b0;
                    m_age  = 0;
                end
            end else if (!ls) begin
                m_wait  = 1'b1;
                m_cause = 2'b11;
                m_wdt   = 0;
            end else if (running) begin
                if (expire) begin
                    m_age   = 0;
                    m_cause = 2'b10;
                    m_wdt   = 0;
                end else if (sw_reset_req) begin
                    m_age   = 0;
                    m_cause = 2'b01;
                    m_wdt   = 0;
                end else begin
                    m_wdt = (wdt_en && !wdt_kick) ? m_wdt + 1 : 0;
                end
            end else begin
                m_age++;
            end
            m_s2 = m_s1;
            m_s1 = locked;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("outs", {26'd0, bus_reset, io_reset, cpu_reset, seq_busy, reset_cause}, {26'd0, model_outs()});
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus_reset;
            1:       return io_reset;
            default: return cpu_reset;
        endcase
    endfunction

    // Step until the chosen reset reaches lvl; at is the edge number.
    task automatic wait_for(input int which, input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sig(which) == lvl) begin
                at = cyc;
                break;
            end
        end
        if (at < 0)
            check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t0, tb, ti, tc;

        reset        = 1'b1;
        locked       = 1'b1;
        sw_reset_req = 1'b0;
        wdt_en       = 1'b0;
        wdt_kick     = 1'b0;

        // Power-up sequence.
        repeat (3) step();
        check("rst_state", {26'd0, bus_reset, io_reset, cpu_reset, seq_busy, reset_cause}, 32'h3c);
        reset = 1'b0;
        t0 = cyc;
        wait_for(0, 1'b0, 30, tb);
        check("pwr_bus", tb - t0, 7);
        wait_for(1, 1'b0, 30, ti);
        check("pwr_io", ti - t0, 9);
        wait_for(2, 1'b0, 30, tc);
        check("pwr_cpu", tc - t0, 11);
        check("pwr_busy", seq_busy, 0);
        check("pwr_cause", reset_cause, 2'b00);

        // Software reset; a second request during HOLD is dropped.
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        t0 = cyc;
        check("sw_enter", {26'd0, bus_reset, io_reset, cpu_reset, seq_busy, reset_cause}, 32'h3d);
        step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        wait_for(0, 1'b0, 30, tb);
        check("sw_bus", tb - t0, 4);
        wait_for(2, 1'b0, 30, tc);
        check("sw_cpu", tc - t0, 8);
        check("sw_cause", reset_cause, 2'b01);

        // Lock loss one cycle after bus release, then replay.
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        wait_for(0, 1'b0, 30, tb);
        step();
        locked = 1'b0;
        t0 = cyc;
        wait_for(0, 1'b1, 10, tb);
        check("lock_lat", ((tb - t0) >= 2 && (tb - t0) <= 3) ? 32'd1 : 32'd0, 32'd1);
        check("lock_cause", reset_cause, 2'b11);
        repeat (4) step();
        check("lock_hold", {26'd0, bus_reset, io_reset, cpu_reset, seq_busy, reset_cause}, 32'h3f);
        locked = 1'b1;
        t0 = cyc;
        wait_for(0, 1'b0, 30, tb);
        check("relock_bus", tb - t0, 7);
        wait_for(1, 1'b0, 30, ti);
        check("relock_io", ti - tb, 2);
        wait_for(2, 1'b0, 30, tc);
        check("relock_cpu", tc - ti, 2);

        // Watchdog expiry with no kick.
        wdt_en = 1'b1;
        t0 = cyc;
        wait_for(2, 1'b1, 30, tc);
        check("wdt_lat", tc - t0, 8);
        check("wdt_cause", reset_cause, 2'b10);

        // Regular kicks keep the system in RUN.
        wait_for(2, 1'b0, 30, tc);
        for (int i = 0; i < 100; i++) begin
            wdt_kick = (i % 6 == 5);
            step();
        end
        wdt_kick = 1'b0;
        check("kick_run", cpu_reset, 1'b0);

        // Kick on the exact expiry cycle wins.
        wdt_kick = 1'b1;
        step();
        wdt_kick = 1'b0;
        repeat (7) step();
        wdt_kick = 1'b1;
        step();
        wdt_kick = 1'b0;
        repeat (3) step();
        check("kick_expiry", cpu_reset, 1'b0);

        // Lock loss beats a simultaneous software request.
        wdt_en = 1'b0;
        locked = 1'b0;
        step();
        step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("prio_cause", reset_cause, 2'b11);
        check("prio_outs", {29'd0, bus_reset, io_reset, cpu_reset}, 32'h7);
        locked = 1'b1;
        wait_for(2, 1'b0, 40, tc);

        // Watchdog disabled, then enabled.
        repeat (50) step();
        check("wdt_off", cpu_reset, 1'b0);
        wdt_en = 1'b1;
        t0 = cyc;
        wait_for(2, 1'b1, 30, tc);
        check("wdt_on_lat", tc - t0, 8);

        // Randomized traffic, every cycle compared with the model.
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0)
                locked = ~locked;
            if ($urandom_range(0, 99) == 0)
                wdt_en = ~wdt_en;
            sw_reset_req = ($urandom_range(0, 39) == 0);
            wdt_kick     = ($urandom_range(0, 6) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
